// File: rtl/bus_pkg.sv
// Shared definitions for the N-master bus arbiter: FSM encoding,
// default bus widths and a constant-evaluable clog2 helper.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } bus_state_t;

    localparam int DEFAULT_AW = 14;
    localparam int DEFAULT_DW = 32;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int bus_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Single-cycle rotating priority picker. Searches req starting at ptr
// and wrapping modulo N; with ptr tied to zero it is a plain
// lowest-index-wins priority encoder.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int   cand;
    logic found;

    // Scan every offset from the pointer; the first requester seen wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDXW'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master arbiter onto one memory port. One-cycle winner selection
// (fixed priority or round-robin), latched request toward memory,
// separate read-response wait, and a DONE hold until the owner
// releases its request.
//
// state | meaning
// IDLE  | no owner; pick a winner when any m_req is set
// ISSUE | mem_valid high, waiting for mem_ready
// WAIT  | read accepted, waiting for mem_rvalid
// DONE  | m_done to owner, waiting for its m_req to drop
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int RR_MODE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  m_req,
    input  logic [N-1:0]  m_we,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*DW-1:0] m_wdata,
    output logic [N-1:0]  m_grant,
    output logic [N-1:0]  m_done,
    output logic [DW-1:0] m_rdata,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    state
);

    localparam int IDXW = (bus_clog2(N) < 1) ? 1 : bus_clog2(N);

    bus_state_t      state_q;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_next;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    done_q;
    logic [DW-1:0]   rdata_q;
    logic            mem_valid_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    logic [IDXW-1:0] pick_ptr;
    logic [N-1:0]    pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // Fixed-priority mode always searches from index 0.
    assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req (m_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // One-hot mux of the winning master's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_we    = m_we[i];
                sel_addr  = m_addr[i*AW +: AW];
                sel_wdata = m_wdata[i*DW +: DW];
            end
        end
    end

    // Pointer wraps at N, never at 2^IDXW.
    assign ptr_next = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;

    // Arbitration FSM with registered grant, done, and memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        idx_q       <= pick_idx;
                        gnt_q       <= pick_gnt;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (mem_we_q) begin
                            done_q  <= gnt_q;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!m_req[idx_q]) begin
                        done_q  <= '0;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                        if (RR_MODE != 0) begin
                            ptr_q <= ptr_next;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_grant   = gnt_q;
    assign m_done    = done_q;
    assign m_rdata   = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign state     = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: round-robin N=4, fixed-priority N=4 and round-robin
// N=3 instances sharing clock, reset and the memory response inputs.
module tb_bus_arbiter_rr;

    localparam int AW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared memory-side inputs
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    // main round-robin instance, N=4 (request fields shared with fixed-priority)
    logic [3:0]      m_req = '0, m_we = '0;
    logic [4*AW-1:0] m_addr = '0;
    logic [4*DW-1:0] m_wdata = '0;
    logic [3:0]      m_grant, m_done;
    logic [DW-1:0]   m_rdata, mem_wdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_valid, mem_we, busy;
    logic [1:0]      state;

    // fixed-priority instance, N=4
    logic [3:0]    fp_req = '0;
    logic [3:0]    fp_grant, fp_done;
    logic [DW-1:0] fp_rdata, fp_mem_wdata;
    logic [AW-1:0] fp_mem_addr;
    logic          fp_mem_valid, fp_mem_we, fp_busy;
    logic [1:0]    fp_state;

    // round-robin instance, N=3
    logic [2:0]      r3_req = '0, r3_we = '0;
    logic [3*AW-1:0] r3_addr = '0;
    logic [3*DW-1:0] r3_wdata = '0;
    logic [2:0]      r3_grant, r3_done;
    logic [DW-1:0]   r3_rdata, r3_mem_wdata;
    logic [AW-1:0]   r3_mem_addr;
    logic            r3_mem_valid, r3_mem_we, r3_busy;
    logic [1:0]      r3_state;

    bus_arbiter_rr #(.N(4), .AW(AW), .DW(DW), .RR_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_grant(m_grant), .m_done(m_done), .m_rdata(m_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .state(state)
    );

    bus_arbiter_rr #(.N(4), .AW(AW), .DW(DW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_req(fp_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_grant(fp_grant), .m_done(fp_done), .m_rdata(fp_rdata),
        .mem_valid(fp_mem_valid), .mem_ready(mem_ready), .mem_we(fp_mem_we),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(fp_busy), .state(fp_state)
    );

    bus_arbiter_rr #(.N(3), .AW(AW), .DW(DW), .RR_MODE(1)) dut_r3 (
        .clk(clk), .rst_n(rst_n),
        .m_req(r3_req), .m_we(r3_we), .m_addr(r3_addr), .m_wdata(r3_wdata),
        .m_grant(r3_grant), .m_done(r3_done), .m_rdata(r3_rdata),
        .mem_valid(r3_mem_valid), .mem_ready(mem_ready), .mem_we(r3_mem_we),
        .mem_addr(r3_mem_addr), .mem_wdata(r3_mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(r3_busy), .state(r3_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_grant", m_grant, 4'b0000);
        check_val("rst_done", m_done, 4'b0000);
        check_val("rst_mem_valid", mem_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_state", state, 2'd0);
        check_val("rst_rdata", m_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write from master 1, mem_ready tied high
        m_req = 4'b0010;
        m_we  = 4'b0010;
        m_addr[1*AW +: AW]  = 14'h0123;
        m_wdata[1*DW +: DW] = 32'hDEADBEEF;
        mem_ready = 1'b1;
        @(negedge clk);
        check_val("wr_grant", m_grant, 4'b0010);
        check_val("wr_mem_valid", mem_valid, 1'b1);
        check_val("wr_mem_addr", mem_addr, 14'h0123);
        check_val("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_val("wr_mem_we", mem_we, 1'b1);
        check_val("wr_state_issue", state, 2'd1);
        @(negedge clk);
        check_val("wr_done", m_done, 4'b0010);
        check_val("wr_mem_valid_low", mem_valid, 1'b0);
        check_val("wr_state_done", state, 2'd3);
        m_req = 4'b0000;
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("wr_idle_state", state, 2'd0);
        check_val("wr_idle_done", m_done, 4'b0000);
        check_val("wr_idle_grant", m_grant, 4'b0000);
        check_val("wr_idle_busy", busy, 1'b0);

        // read from master 0 with late mem_ready and delayed rvalid (pointer now 2, wraps to 0)
        m_req = 4'b0001;
        m_we  = 4'b0000;
        m_addr[0*AW +: AW] = 14'h0040;
        @(negedge clk);
        check_val("rd_grant", m_grant, 4'b0001);
        check_val("rd_mem_valid", mem_valid, 1'b1);
        check_val("rd_mem_addr", mem_addr, 14'h0040);
        check_val("rd_mem_we", mem_we, 1'b0);
        for (int s = 0; s < 3; s++) begin
            mem_rvalid = (s == 1);
            mem_rdata  = 32'h11111111;
            @(negedge clk);
            check_val($sformatf("rd_stall_state%0d", s), state, 2'd1);
            check_val($sformatf("rd_stall_valid%0d", s), mem_valid, 1'b1);
            check_val($sformatf("rd_stall_addr%0d", s), mem_addr, 14'h0040);
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        @(negedge clk);
        check_val("rd_wait_state", state, 2'd2);
        check_val("rd_wait_valid", mem_valid, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("rd_wait_state2", state, 2'd2);
        check_val("rd_wait_done", m_done, 4'b0000);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h48474645;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("rd_done", m_done, 4'b0001);
        check_val("rd_rdata", m_rdata, 32'h48474645);
        check_val("rd_state_done", state, 2'd3);
        m_req = 4'b0000;
        @(negedge clk);
        check_val("rd_idle_state", state, 2'd0);
        check_val("rd_idle_done", m_done, 4'b0000);

        // round-robin fairness from a fresh pointer of 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_addr[i*AW +: AW]  = AW'(14'h0100 + i);
            m_wdata[i*DW +: DW] = 32'hA0000000 + i;
        end
        m_we = 4'b1111;
        mem_ready = 1'b1;
        m_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (m_done == 4'b0000 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check_val($sformatf("rr_order%0d", k), m_done, 4'b0001 << rr_exp[k]);
            check_val($sformatf("rr_grant%0d", k), m_grant, 4'b0001 << rr_exp[k]);
            check_val($sformatf("rr_addr%0d", k), mem_addr, 14'h0100 + rr_exp[k]);
            m_req[rr_exp[k]] = 1'b0;
            @(negedge clk);
            check_val($sformatf("rr_gap%0d", k), state, 2'd0);
            m_req = 4'b1111;
        end
        m_req = 4'b0000;

        // fixed priority: master 0 wins every time
        fp_req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (fp_done == 4'b0000 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check_val($sformatf("fp_order%0d", k), fp_done, 4'b0001);
            fp_req[0] = 1'b0;
            @(negedge clk);
            check_val($sformatf("fp_gap%0d", k), fp_state, 2'd0);
            fp_req = 4'b1111;
        end
        fp_req = 4'b0000;
        @(negedge clk);

        // N=3 wrap: master 1 first moves the pointer to 2
        r3_we  = 3'b111;
        r3_req = 3'b010;
        w = 0;
        while (r3_done == 3'b000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("n3_first_done", r3_done, 3'b010);
        r3_req = 3'b000;
        @(negedge clk);
        check_val("n3_idle1", r3_state, 2'd0);
        r3_req = 3'b011;
        @(negedge clk);
        check_val("n3_wrap_grant", r3_grant, 3'b001);
        w = 0;
        while (r3_done == 3'b000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("n3_wrap_done", r3_done, 3'b001);
        r3_req = 3'b010;
        @(negedge clk);
        check_val("n3_idle2", r3_state, 2'd0);
        @(negedge clk);
        check_val("n3_next_grant", r3_grant, 3'b010);
        w = 0;
        while (r3_done == 3'b000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("n3_next_done", r3_done, 3'b010);
        r3_req = 3'b000;
        @(negedge clk);

        // early release: master 1 drops m_req while in WAIT (pointer is 1)
        m_we  = 4'b0000;
        m_addr[1*AW +: AW] = 14'h0077;
        m_req = 4'b0010;
        mem_ready = 1'b1;
        @(negedge clk);
        check_val("er_grant", m_grant, 4'b0010);
        @(negedge clk);
        check_val("er_wait", state, 2'd2);
        m_req = 4'b0000;
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("er_still_wait", state, 2'd2);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("er_done", m_done, 4'b0010);
        check_val("er_rdata", m_rdata, 32'hCAFEF00D);
        @(negedge clk);
        check_val("er_done_clear", m_done, 4'b0000);
        check_val("er_idle", state, 2'd0);

        // reset mid-read: master 3 in WAIT (pointer is 2)
        m_req = 4'b1000;
        mem_ready = 1'b1;
        @(negedge clk);
        check_val("mr_grant", m_grant, 4'b1000);
        @(negedge clk);
        check_val("mr_wait", state, 2'd2);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mr_rst_grant", m_grant, 4'b0000);
        check_val("mr_rst_busy", busy, 1'b0);
        check_val("mr_rst_valid", mem_valid, 1'b0);
        check_val("mr_rst_done", m_done, 4'b0000);
        check_val("mr_rst_state", state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_we  = 4'b1010;
        m_req = 4'b1010;
        mem_ready = 1'b1;
        @(negedge clk);
        check_val("mr_post_grant", m_grant, 4'b0010);
        w = 0;
        while (m_done == 4'b0000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("mr_post_done", m_done, 4'b0010);
        m_req = 4'b0000;
        @(negedge clk);
        check_val("mr_post_idle", state, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
